get_ports_rr_arbiter: RTL and testbench
=======================================

Name: get_ports_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one registered adder datapath (sum of two operands, gated by a valid) between NUM_REQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, registers the sum tagged with the requester index, and holds it until the downstream consumer accepts it. It sits between multiple operand sources and a single result sink in the timing-coverage netlists, exercising port-pattern, multi-source and clock-to-output paths.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, operand width in bits
ID_W, $clog2(NUM_REQ), requester index width (derived localparam, not overridable)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept, one-hot or zero
req_data1  input  NUM_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
req_data2  input  NUM_REQ*DATA_W  packed operand B, same packing
result_valid  output  1  registered result available
result_ready  input  1  downstream accepts result
result_data  output  DATA_W+1  registered sum, carry kept
result_id  output  ID_W  index of requester that produced result_data

Behaviour:
- Reset (async assert, sync release via clk edge): result_valid=0, result_data=0, result_id=0, rr_ptr=0, state=IDLE. req_ready is combinational and therefore 0 while rst=1.
- States: IDLE (output register empty) and FULL (result held).
- can_accept = (state==IDLE) | (result_ready & result_valid).
- Grant:
  - Combinational search from rr_ptr upward, wrapping at NUM_REQ-1 to 0.
  - First i with req_valid[i]=1 wins.
  - req_ready[i] = can_accept & win[i]; all other req_ready bits are 0.
- Accept (req_valid[i] & req_ready[i]) at edge N:
  - result_data <= zero-extended data1 + data2 (DATA_W+1 bits, no truncation).
  - result_id <= i.
  - result_valid=1 from cycle N+1, so latency is exactly 1 cycle.
  - rr_ptr <= (i==NUM_REQ-1) ? 0 : i+1.
  - state <= FULL.
- FULL with result_ready=1 and no new grant: result_valid<=0, state<=IDLE; result_data/result_id keep their old values.
- FULL with result_ready=1 and a new grant in the same cycle: pass-through, result replaced back-to-back, result_valid stays 1, throughput 1 result/cycle.
- FULL with result_ready=0: result_data/result_id held stable, all req_ready=0 (backpressure).
- No valid requests: rr_ptr unchanged.
- Requester inputs are only sampled on handshake; a requester may drop req_valid without penalty.
- Reset mid-operation: held result discarded, fairness restarts from index 0.
- Max sum (all-ones + all-ones) = 2^(DATA_W+1)-2, with the MSB set.

Optional Feature:
Macro ARB_GRANT_COUNT_EN.
- When defined:
  - Extra output grant_count, NUM_REQ*16 bits.
  - One saturating 16-bit counter per requester, incremented on each accepted handshake, stuck at 0xFFFF.
  - Reset to 0.
  - Extra input grant_count_clr (1 bit): synchronous clear of all counters, which takes priority over a same-cycle increment.
- When undefined: neither port nor counters exist; behaviour is otherwise identical.

Decomposition:
- Shared package get_ports_pkg:
  - localparam default DATA_W.
  - Function clog2_min1 (returns at least 1).
  - Typedef arb_state_t {IDLE, FULL}.
- One natural sub-module: rr_pick. Inputs req vector and ptr; outputs one-hot win and its encoded index. It is purely combinational and reused by other arbiters in the suite.

Test Plan:
- Reset then single request: req_valid=4'b0010, data1=8'h7F, data2=8'h01, result_ready=1 -> next cycle result_valid=1, result_data=9'h080, result_id=1; rr_ptr=2.
- All four requesting continuously, result_ready=1 -> result_id sequence 0,1,2,3,0,1, with one result per cycle and no bubbles.
- Backpressure: result held with result_ready=0 for 3 cycles, req_valid=4'b1111 -> req_ready=0 throughout, result_data stable; ready=1 then grants the next index in rotation.
- Overflow: data1=data2=8'hFF -> result_data=9'h1FE.
- Reset mid-hold: rst pulsed while result_valid=1 -> result_valid falls asynchronously; after release, request on idx 3 only gives result_id=3, and a subsequent all-request gives id 0 first.
- With ARB_GRANT_COUNT_EN: 5 grants to idx 2, then grant_count_clr asserted together with a grant -> count for idx 2 reads 0 next cycle.

Source files
------------

// File: rtl/get_ports_pkg.sv
// -----------------------------------------------------------------------------
// get_ports_pkg
// Shared definitions for the get_ports arbiter family.
//   DATA_W_DEF  : default operand width
//   clog2_min1  : ceil(log2(n)), never less than 1 (safe for index widths)
//   arb_state_t : output-register occupancy state (IDLE = empty, FULL = held)
// -----------------------------------------------------------------------------
package get_ports_pkg;

    localparam int DATA_W_DEF = 8;

    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. Searches req_i starting at ptr_i,
// wrapping from N-1 back to 0; the first set bit wins.
// Ports:
//   req_i  [N-1:0]      request vector
//   ptr_i  [IDX_W-1:0]  highest-priority index for this search (< N)
//   win_o  [N-1:0]      one-hot winner, zero when no request
//   idx_o  [IDX_W-1:0]  encoded winner index, zero when no request
//   any_o               at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     win_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    int j;

    // NOTE: every output gets a default before the search so no path through
    // the loop leaves a value unassigned, which would infer a latch.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!any_o && req_i[j]) begin
                win_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/get_ports_rr_arbiter.sv
// -----------------------------------------------------------------------------
// get_ports_rr_arbiter
// Round-robin sharing of one registered adder between NUM_REQ requesters.
// The granted requester's operands are summed (carry kept) into an output
// register tagged with the requester index, held until the sink accepts it.
// Back-to-back results are possible when the sink accepts while a new grant
// is made in the same cycle.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready [NUM_REQ]  per-requester handshake (ready one-hot/zero)
//   req_data1/req_data2            packed operands, lane i at [i*DATA_W +: DATA_W]
//   result_valid/result_ready      output handshake
//   result_data [DATA_W+1]         registered sum
//   result_id   [ID_W]             index of the requester that produced it
// Optional (macro ARB_GRANT_COUNT_EN):
//   grant_count_clr                sync clear of all grant counters (wins over +1)
//   grant_count [NUM_REQ*16]       saturating 16-bit accept count per requester
// -----------------------------------------------------------------------------
module get_ports_rr_arbiter
    import get_ports_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int ID_W    = clog2_min1(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ARB_GRANT_COUNT_EN
    input  logic                        grant_count_clr,
    output logic [NUM_REQ*16-1:0]       grant_count,
`endif
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data1,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data2,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [DATA_W:0]             result_data,
    output logic [ID_W-1:0]             result_id
);

    arb_state_t          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W:0]     result_data_q, result_data_d;
    logic [ID_W-1:0]     result_id_q, result_id_d;

    logic [NUM_REQ-1:0]  win;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_any;
    logic                can_accept;
    logic                accept;
    logic [DATA_W-1:0]   op_a, op_b;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .win_o (win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // A new operand pair can be taken when the output register is empty or is
    // being emptied this same cycle. Gated by rst so no handshake is offered
    // while the block is held in reset.
    assign can_accept = !rst && ((state_q == IDLE) || result_ready);
    assign req_ready  = can_accept ? win : '0;
    assign accept     = can_accept && pick_any;

    assign op_a = req_data1[pick_idx*DATA_W +: DATA_W];
    assign op_b = req_data2[pick_idx*DATA_W +: DATA_W];

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        result_data_d = result_data_q;
        result_id_d   = result_id_q;

        if (accept) begin
            state_d       = FULL;
            result_data_d = {1'b0, op_a} + {1'b0, op_b};
            result_id_d   = pick_idx;
            rr_ptr_d      = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (state_q == FULL && result_ready) begin
            // Drained with no replacement: data/id intentionally left as-is.
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            result_data_q <= '0;
            result_id_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            result_data_q <= result_data_d;
            result_id_q   <= result_id_d;
        end
    end

    assign result_valid = (state_q == FULL);
    assign result_data  = result_data_q;
    assign result_id    = result_id_q;

`ifdef ARB_GRANT_COUNT_EN
    logic [NUM_REQ-1:0] hs;
    assign hs = req_valid & req_ready;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] cnt_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (grant_count_clr) begin
                cnt_q <= '0;
            end else if (hs[g] && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign grant_count[g*16 +: 16] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_get_ports_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_get_ports_rr_arbiter
// Directed self-checking bench for get_ports_rr_arbiter (NUM_REQ=4, DATA_W=8).
// Inputs change on the falling edge; outputs are checked on the falling edge
// or 1 time unit after an input change for combinational req_ready.
// -----------------------------------------------------------------------------
module tb_get_ports_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data1;
    logic [NUM_REQ*DATA_W-1:0] req_data2;
    logic                      result_valid;
    logic                      result_ready;
    logic [DATA_W:0]           result_data;
    logic [ID_W-1:0]           result_id;
`ifdef ARB_GRANT_COUNT_EN
    logic                      grant_count_clr;
    logic [NUM_REQ*16-1:0]     grant_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    get_ports_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
`ifdef ARB_GRANT_COUNT_EN
        .grant_count_clr (grant_count_clr),
        .grant_count     (grant_count),
`endif
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data1       (req_data1),
        .req_data2       (req_data2),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_data     (result_data),
        .result_id       (result_id)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Lane i carries data1 = 0x10*i + 1 and data2 = 0x02, so its sum is 0x10*i + 3.
    task automatic load_lanes();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data1[i*DATA_W +: DATA_W] = 8'(8'h10 * i + 1);
            req_data2[i*DATA_W +: DATA_W] = 8'h02;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [DATA_W:0] held;

    initial begin
        rst          = 1'b1;
        req_valid    = 4'b1111;
        req_data1    = '0;
        req_data2    = '0;
        result_ready = 1'b0;
`ifdef ARB_GRANT_COUNT_EN
        grant_count_clr = 1'b0;
`endif
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_valid", 32'(result_valid), 32'h0);
        check("rst_data", 32'(result_data), 32'h0);
        check("rst_id", 32'(result_id), 32'h0);

        // Single request on index 1: 0x7F + 0x01 = 0x080.
        @(negedge clk);
        rst          = 1'b0;
        req_valid    = 4'b0010;
        req_data1[1*DATA_W +: DATA_W] = 8'h7F;
        req_data2[1*DATA_W +: DATA_W] = 8'h01;
        result_ready = 1'b1;
        #1 check("single_ready", 32'(req_ready), 32'h2);
        step();
        check("single_valid", 32'(result_valid), 32'h1);
        check("single_data", 32'(result_data), 32'h080);
        check("single_id", 32'(result_id), 32'h1);
        req_valid = 4'b1111;
        #1 check("ptr_after_1", 32'(req_ready), 32'h4);

        // Restart fairness from 0, then all four request continuously.
        rst = 1'b1;
        #1 rst = 1'b0;
        load_lanes();
        for (int c = 0; c < 6; c++) begin
            step();
            check("rr_valid", 32'(result_valid), 32'h1);
            check("rr_id", 32'(result_id), 32'(c % NUM_REQ));
            check("rr_data", 32'(result_data), 32'(8'h10 * (c % NUM_REQ) + 3));
        end

        // Backpressure: id 1 result held, no grants for 3 cycles.
        held         = 9'h013;
        result_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check("bp_ready", 32'(req_ready), 32'h0);
            step();
            check("bp_valid", 32'(result_valid), 32'h1);
            check("bp_data", 32'(result_data), 32'(held));
            check("bp_id", 32'(result_id), 32'h1);
        end
        result_ready = 1'b1;
        #1 check("bp_release_ready", 32'(req_ready), 32'h4);
        step();
        check("bp_next_id", 32'(result_id), 32'h2);
        check("bp_next_data", 32'(result_data), 32'h023);

        // Drain with no new request: valid drops, data/id retained.
        req_valid = 4'b0000;
        step();
        check("drain_valid", 32'(result_valid), 32'h0);
        check("drain_data", 32'(result_data), 32'h023);
        check("drain_id", 32'(result_id), 32'h2);
        #1 check("idle_ready", 32'(req_ready), 32'h0);

        // Overflow on lane 0 (pointer is 3, search wraps to 0).
        req_valid = 4'b0001;
        req_data1[0 +: DATA_W] = 8'hFF;
        req_data2[0 +: DATA_W] = 8'hFF;
        step();
        check("ovf_valid", 32'(result_valid), 32'h1);
        check("ovf_data", 32'(result_data), 32'h1FE);
        check("ovf_id", 32'(result_id), 32'h0);

        // Reset while a result is held.
        req_valid    = 4'b0000;
        result_ready = 1'b0;
        step();
        check("hold_pre_rst", 32'(result_valid), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(result_valid), 32'h0);
        check("mid_rst_data", 32'(result_data), 32'h0);
        #1 rst = 1'b0;
        result_ready = 1'b1;
        req_valid    = 4'b1111;
        #1 check("post_rst_ptr", 32'(req_ready), 32'h1);
        req_valid = 4'b1000;
        #1 check("post_rst_ready3", 32'(req_ready), 32'h8);
        step();
        check("post_rst_id3", 32'(result_id), 32'h3);
        req_valid = 4'b1111;
        step();
        check("post_rst_id0", 32'(result_id), 32'h0);

`ifdef ARB_GRANT_COUNT_EN
        // Counter: 5 grants to index 2, then clear together with a grant.
        rst = 1'b1;
        #1 rst = 1'b0;
        check("cnt_rst", 32'(grant_count[2*16 +: 16]), 32'h0);
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) step();
        check("cnt_five", 32'(grant_count[2*16 +: 16]), 32'd5);
        check("cnt_other", 32'(grant_count[1*16 +: 16]), 32'h0);
        grant_count_clr = 1'b1;
        #1 check("cnt_clr_ready", 32'(req_ready), 32'h4);
        step();
        grant_count_clr = 1'b0;
        check("cnt_clr", 32'(grant_count[2*16 +: 16]), 32'h0);
        step();
        check("cnt_after_clr", 32'(grant_count[2*16 +: 16]), 32'd1);
`endif

        req_valid = '0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
